// File: rtl/conv_row_arbiter_if.sv
// Handshake bundle between the row producers, conv_row_arbiter and conv_engine.
// The slave modport is the arbiter view; master is the producer/engine view.
interface conv_row_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ROW_W   = 256
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*ROW_W-1:0] req_row;
   logic [NUM_REQ-1:0]       req_grant;
   logic [NUM_REQ-1:0]       resp_valid;
   logic                     busy;
   logic                     eng_start;
   logic [ROW_W-1:0]         eng_row;
   logic                     eng_done;
   logic                     err_timeout;

   modport master (
      output req_valid, req_row, eng_done,
      input  req_grant, resp_valid, busy, eng_start, eng_row, err_timeout
   );

   modport slave (
      input  req_valid, req_row, eng_done,
      output req_grant, resp_valid, busy, eng_start, eng_row, err_timeout
   );
endinterface

// File: rtl/conv_row_arbiter.sv
// Round-robin sequencer sharing one conv_engine among NUM_REQ row producers.
// Optional engine watchdog enabled by defining CONV_ARB_WATCHDOG_EN.
module conv_row_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ROW_W   = 256,
   parameter int unsigned TIMEOUT = 128
) (
   input logic             clk,
   input logic             rst_n,
   conv_row_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("conv_row_arbiter: NUM_REQ must be 2..8");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("conv_row_arbiter: TIMEOUT must fit the 8-bit watchdog");
   end

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [ROW_W-1:0]   eng_row_q, eng_row_d;
   logic [NUM_REQ-1:0] req_grant_q, req_grant_d;
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic               busy_q, busy_d;
   logic               eng_start_q, eng_start_d;

`ifdef CONV_ARB_WATCHDOG_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   logic [7:0]         wd_cnt_q, wd_cnt_d;
   logic               err_timeout_q, err_timeout_d;
`endif

   logic [ROW_W-1:0]   row_arr [NUM_REQ];
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [PTR_W:0]     scan;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rows
      assign row_arr[g] = bus.req_row[g*ROW_W +: ROW_W];
   end

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if ({1'b0, p} == (PTR_W+1)'(NUM_REQ - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Scan offsets 0..NUM_REQ-1 from rr_ptr; the first pending requester wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      scan  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
         if (!found && bus.req_valid[scan[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = scan[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      eng_row_d    = eng_row_q;
      req_grant_d  = '0;
      resp_valid_d = '0;
      busy_d       = busy_q;
      eng_start_d  = 1'b0;
`ifdef CONV_ARB_WATCHDOG_EN
      wd_cnt_d      = wd_cnt_q;
      err_timeout_d = err_timeout_q;
`endif
      // Outputs are registered one state ahead so they line up with the state they describe.
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (found) begin
               owner_d          = win;
               eng_row_d        = row_arr[win];
               req_grant_d[win] = 1'b1;
               busy_d           = 1'b1;
               state_d          = S_START;
            end
         end
         S_START: begin
            eng_start_d = 1'b1;
`ifdef CONV_ARB_WATCHDOG_EN
            wd_cnt_d    = '0;
`endif
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (bus.eng_done) begin
               resp_valid_d[owner_q] = 1'b1;
               state_d               = S_RESP;
            end
`ifdef CONV_ARB_WATCHDOG_EN
            else if (wd_cnt_q == WD_LAST) begin
               err_timeout_d = 1'b1;
               rr_ptr_d      = next_ptr(owner_q);
               busy_d        = 1'b0;
               state_d       = S_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 8'd1;
            end
`endif
         end
         S_RESP: begin
            rr_ptr_d = next_ptr(owner_q);
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         owner_q       <= '0;
         eng_row_q     <= '0;
         req_grant_q   <= '0;
         resp_valid_q  <= '0;
         busy_q        <= 1'b0;
         eng_start_q   <= 1'b0;
`ifdef CONV_ARB_WATCHDOG_EN
         wd_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         owner_q       <= owner_d;
         eng_row_q     <= eng_row_d;
         req_grant_q   <= req_grant_d;
         resp_valid_q  <= resp_valid_d;
         busy_q        <= busy_d;
         eng_start_q   <= eng_start_d;
`ifdef CONV_ARB_WATCHDOG_EN
         wd_cnt_q      <= wd_cnt_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

   assign bus.req_grant  = req_grant_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.busy       = busy_q;
   assign bus.eng_start  = eng_start_q;
   assign bus.eng_row    = eng_row_q;
`ifdef CONV_ARB_WATCHDOG_EN
   assign bus.err_timeout = err_timeout_q;
`else
   assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_conv_row_arbiter.sv
// Directed bench for conv_row_arbiter: reset, single row, contention, wrap, stray done, watchdog.
module tb_conv_row_arbiter;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ROW_W   = 256;
   localparam int unsigned TIMEOUT = 128;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic exp_err = 1'b0;
   logic [ROW_W-1:0] rows [NUM_REQ];

   always #5 clk = ~clk;

   conv_row_arbiter_if #(.NUM_REQ(NUM_REQ), .ROW_W(ROW_W)) bus ();

   conv_row_arbiter #(.NUM_REQ(NUM_REQ), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rows();
      bus.req_row = {rows[3], rows[2], rows[1], rows[0]};
   endtask

   // Starts in an IDLE cycle with the request already driven; runs one short row.
   task automatic serve(input int unsigned w);
      int unsigned waits;
      logic [NUM_REQ-1:0] g;
      g = NUM_REQ'(1) << w;
      waits = 0;
      while (bus.req_grant == '0 && waits < 12) begin
         step();
         waits++;
      end
      chk($sformatf("serve%0d_latency", w), waits, 1);
      chk($sformatf("serve%0d_grant", w), bus.req_grant, g);
      chk($sformatf("serve%0d_row", w), bus.eng_row, rows[w]);
      chk($sformatf("serve%0d_nostart", w), bus.eng_start, 1'b0);
      step();
      chk($sformatf("serve%0d_start", w), bus.eng_start, 1'b1);
      chk($sformatf("serve%0d_grant_clr", w), bus.req_grant, '0);
      step();
      bus.eng_done = 1'b1;
      step();
      bus.eng_done = 1'b0;
      chk($sformatf("serve%0d_resp", w), bus.resp_valid, g);
      chk($sformatf("serve%0d_busy_resp", w), bus.busy, 1'b1);
      step();
      chk($sformatf("serve%0d_resp_clr", w), bus.resp_valid, '0);
      chk($sformatf("serve%0d_busy_clr", w), bus.busy, 1'b0);
      chk($sformatf("serve%0d_err", w), bus.err_timeout, exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rows[0] = {32{8'hA0}};
      rows[1] = {32{8'hB1}};
      rows[2] = {32{8'h0F}};
      rows[3] = {32{8'hC3}};
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.eng_done  = 1'b0;
      load_rows();
      step();
      step();
      chk("rst_grant", bus.req_grant, '0);
      chk("rst_resp", bus.resp_valid, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_start", bus.eng_start, 1'b0);
      chk("rst_row", bus.eng_row, '0);
      chk("rst_err", bus.err_timeout, 1'b0);
      rst_n = 1'b1;

      // single row on requester 2, engine finishing at T+67
      bus.req_valid = 4'b0100;
      step();
      chk("t2_grant", bus.req_grant, 4'b0100);
      chk("t2_nostart", bus.eng_start, 1'b0);
      chk("t2_busy", bus.busy, 1'b1);
      chk("t2_row", bus.eng_row, rows[2]);
      bus.req_valid = '0;
      step();
      chk("t2_start", bus.eng_start, 1'b1);
      chk("t2_grant_clr", bus.req_grant, '0);
      for (int c = 2; c <= 67; c++) begin
         if (c == 10) bus.req_row[2*ROW_W +: ROW_W] = ~rows[2];
         step();
         chk($sformatf("t2_hold_row_c%0d", c), bus.eng_row, rows[2]);
         chk($sformatf("t2_no_resp_c%0d", c), bus.resp_valid, '0);
      end
      bus.eng_done = 1'b1;
      step();
      bus.eng_done = 1'b0;
      chk("t2_resp", bus.resp_valid, 4'b0100);
      chk("t2_busy_resp", bus.busy, 1'b1);
      step();
      chk("t2_resp_clr", bus.resp_valid, '0);
      chk("t2_busy_clr", bus.busy, 1'b0);
      load_rows();

      // reset mid-WAIT: rr_ptr is 3, so requester 2 still wins here
      bus.req_valid = 4'b0100;
      step();
      chk("t1_grant", bus.req_grant, 4'b0100);
      bus.req_valid = '0;
      step();
      step();
      step();
      chk("t1_busy_wait", bus.busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_busy", bus.busy, 1'b0);
      chk("t1_row", bus.eng_row, '0);
      chk("t1_start", bus.eng_start, 1'b0);
      chk("t1_grant_z", bus.req_grant, '0);
      chk("t1_resp", bus.resp_valid, '0);
      step();
      rst_n = 1'b1;
      chk("t1_no_resp_after", bus.resp_valid, '0);

      // contention from rr_ptr=0 confirms the pointer was reset
      bus.req_valid = 4'b1111;
      serve(0);
      serve(1);
      serve(2);
      serve(3);
      serve(0);
      serve(1);
      serve(2);
      serve(3);

      // wrap after owner 3
      bus.req_valid = 4'b1001;
      serve(0);
      serve(3);
      bus.req_valid = '0;

      // stray eng_done in IDLE and in START
      bus.eng_done = 1'b1;
      step();
      chk("t5_idle_grant", bus.req_grant, '0);
      chk("t5_idle_resp", bus.resp_valid, '0);
      chk("t5_idle_busy", bus.busy, 1'b0);
      bus.eng_done  = 1'b0;
      bus.req_valid = 4'b0001;
      step();
      chk("t5_grant", bus.req_grant, 4'b0001);
      bus.req_valid = '0;
      bus.eng_done  = 1'b1;
      step();
      chk("t5_start", bus.eng_start, 1'b1);
      chk("t5_start_resp", bus.resp_valid, '0);
      bus.eng_done = 1'b0;
      step();
      chk("t5_wait_resp", bus.resp_valid, '0);
      chk("t5_wait_busy", bus.busy, 1'b1);
      step();
      chk("t5_wait_busy2", bus.busy, 1'b1);
      bus.eng_done = 1'b1;
      step();
      bus.eng_done = 1'b0;
      chk("t5_resp", bus.resp_valid, 4'b0001);
      step();
      chk("t5_busy_clr", bus.busy, 1'b0);

`ifdef CONV_ARB_WATCHDOG_EN
      // engine never finishes: flag TIMEOUT cycles after eng_start
      bus.req_valid = 4'b0010;
      step();
      chk("t6_grant", bus.req_grant, 4'b0010);
      bus.req_valid = '0;
      step();
      chk("t6_start", bus.eng_start, 1'b1);
      for (int c = 1; c < int'(TIMEOUT); c++) step();
      chk("t6_err_before", bus.err_timeout, 1'b0);
      chk("t6_busy_before", bus.busy, 1'b1);
      step();
      chk("t6_err", bus.err_timeout, 1'b1);
      chk("t6_no_resp", bus.resp_valid, '0);
      chk("t6_busy_clr", bus.busy, 1'b0);
      exp_err = 1'b1;
      bus.req_valid = 4'b0100;
      serve(2);
      bus.req_valid = '0;
      step();
      chk("t6_err_sticky", bus.err_timeout, 1'b1);
`else
      bus.req_valid = 4'b0010;
      serve(1);
      bus.req_valid = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
